// File: rtl/mfp_uart_transmitter_if.sv
// mfp_uart_transmitter_if: byte-push bus between the AHB-Lite
// GPIO/UART slave and the UART transmit FIFO.
interface mfp_uart_transmitter_if #(
  parameter int FIFO_DEPTH = 16
);
  logic                          wr_en;
  logic [7:0]                    wr_data;
  logic                          full;
  logic                          empty;
  logic [$clog2(FIFO_DEPTH):0]   count;

  modport master (
    output wr_en,
    output wr_data,
    input  full,
    input  empty,
    input  count
  );

  modport slave (
    input  wr_en,
    input  wr_data,
    output full,
    output empty,
    output count
  );
endinterface

// File: rtl/mfp_uart_transmitter.sv
// mfp_uart_transmitter: 8N1 UART transmitter with a transmit FIFO.
// Bytes go out LSB-first; tx idles high and comes straight from a flop.
module mfp_uart_transmitter #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  mfp_uart_transmitter_if.slave bus,
  output logic                 busy,
  output logic                 tx
);
  localparam int DIV = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int BW  = (DIV < 2) ? 1 : $clog2(DIV);

  if (DIV < 2) begin : g_div_chk
    $error("mfp_uart_transmitter: baud divider must be >= 2");
  end
  if (FIFO_DEPTH < 2 || (1 << AW) != FIFO_DEPTH) begin : g_depth_chk
    $error("mfp_uart_transmitter: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_nxt;
  logic          full_q;
  logic          empty_q;

  logic          bit_end;
  logic          pop;
  logic          push;
  logic [7:0]    head;

  assign bit_end = (baud == BW'(DIV - 1));
  // A pop frees a slot in the same cycle, so a push into a full FIFO
  // is still accepted when it coincides with a pop.
  assign pop  = !empty_q &&
                ((state == IDLE) || (state == STOP && bit_end));
  assign push = bus.wr_en && (!full_q || pop);
  assign head = mem[rptr];

  assign bus.full  = full_q;
  assign bus.empty = empty_q;
  assign bus.count = count_q;

  // Next FIFO occupancy from this cycle's push/pop pair.
  always_comb begin
    count_nxt = count_q;
    if (push && !pop) begin
      count_nxt = count_q + 1'b1;
    end else if (pop && !push) begin
      count_nxt = count_q - 1'b1;
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= bus.wr_data;
    end
  end

  // FIFO pointers and registered occupancy flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      count_q <= count_nxt;
      full_q  <= (count_nxt == CW'(FIFO_DEPTH));
      empty_q <= (count_nxt == '0);
    end
  end

  // Serializer FSM with registered tx/busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          baud <= '0;
          if (pop) begin
            shift <= head;
            state <= START;
            tx    <= 1'b0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            baud    <= '0;
            bit_idx <= '0;
            tx      <= shift[0];
            state   <= DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud <= '0;
            if (pop) begin
              shift <= head;
              tx    <= 1'b0;
              state <= START;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mfp_uart_transmitter.sv
// tb_mfp_uart_transmitter: directed and scoreboard bench for the
// UART transmitter at DIV=10, FIFO_DEPTH=4.
module tb_mfp_uart_transmitter;
  localparam int DIV   = 10;
  localparam int DEPTH = 4;
  localparam int FL    = 10 * DIV;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy;
  logic tx;

  mfp_uart_transmitter_if #(.FIFO_DEPTH(DEPTH)) bus ();

  mfp_uart_transmitter #(
    .CLK_FREQ  (1_000_000),
    .BAUD_RATE (100_000),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .busy (busy),
    .tx   (tx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    return b[j-1];
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || !bus.empty) && n < 2000) begin
      tick();
      n++;
    end
    check("idle wait", 32'(n < 2000), 1);
  endtask

  // Check tx/busy/empty sample by sample; k counts cycles from the
  // first start-bit sample. Optionally push one byte before edge k+1.
  task automatic expect_stream(input logic [7:0] q[$],
                               input int k0,
                               input int push_k,
                               input logic [7:0] push_b,
                               input string tag);
    int n;
    n = q.size();
    for (int k = k0; k < FL * n; k++) begin
      check({tag, " tx"}, 32'(tx),
            32'(frame_bit(q[k / FL], (k % FL) / DIV)));
      check({tag, " busy"}, 32'(busy), 1);
      check({tag, " empty"}, 32'(bus.empty), 32'(k >= FL * (n - 1)));
      if (k == push_k + 1) begin
        check({tag, " count"}, 32'(bus.count), DEPTH);
        check({tag, " full"}, 32'(bus.full), 1);
      end
      if (k == push_k) begin
        bus.wr_en   = 1'b1;
        bus.wr_data = push_b;
      end
      tick();
      bus.wr_en = 1'b0;
    end
    check({tag, " end busy"}, 32'(busy), 0);
    check({tag, " end tx"}, 32'(tx), 1);
  endtask

  initial begin
    logic [7:0] q[$];
    int lows;
    int bsy;

    vecs[0] = '{data: 8'hA5, frame: 10'b1_1010_0101_0};
    vecs[1] = '{data: 8'h00, frame: 10'b1_0000_0000_0};
    vecs[2] = '{data: 8'hFF, frame: 10'b1_1111_1111_0};
    vecs[3] = '{data: 8'h3C, frame: 10'b1_0011_1100_0};
    vecs[4] = '{data: 8'h81, frame: 10'b1_1000_0001_0};

    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;

    // reset state
    tick();
    tick();
    check("rst tx", 32'(tx), 1);
    check("rst busy", 32'(busy), 0);
    check("rst empty", 32'(bus.empty), 1);
    check("rst full", 32'(bus.full), 0);
    check("rst count", 32'(bus.count), 0);
    reset = 1'b0;
    tick();

    // single frames from the vector table
    foreach (vecs[v]) begin
      wait_idle();
      bus.wr_en   = 1'b1;
      bus.wr_data = vecs[v].data;
      tick();
      bus.wr_en = 1'b0;
      check("t1 tx before start", 32'(tx), 1);
      check("t1 count", 32'(bus.count), 1);
      tick();
      for (int k = 0; k < FL; k++) begin
        check("t1 tx", 32'(tx), 32'(vecs[v].frame[k / DIV]));
        check("t1 busy", 32'(busy), 1);
        tick();
      end
      check("t1 busy after", 32'(busy), 0);
      check("t1 tx after", 32'(tx), 1);
    end

    // three back-to-back frames
    wait_idle();
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h00;
    tick();
    bus.wr_data = 8'hFF;
    tick();
    check("t2 first low", 32'(tx), 0);
    bus.wr_data = 8'h55;
    tick();
    bus.wr_en = 1'b0;
    q = {8'h00, 8'hFF, 8'h55};
    expect_stream(q, 1, -10, 8'h00, "t2");

    // overflow: six pushes, sixth dropped
    wait_idle();
    bus.wr_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.wr_data = 8'(8'h11 * (i + 1));
      tick();
    end
    bus.wr_en = 1'b0;
    check("t3 full", 32'(bus.full), 1);
    check("t3 count", 32'(bus.count), DEPTH);
    q = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    expect_stream(q, 4, -10, 8'h00, "t3");
    lows = 0;
    repeat (3 * FL) begin
      if (!tx) lows++;
      tick();
    end
    check("t3 no sixth frame", 32'(lows), 0);

    // push into a full FIFO on the cycle of a pop
    wait_idle();
    bus.wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.wr_data = 8'(8'hC1 + i);
      tick();
    end
    bus.wr_en = 1'b0;
    check("t4 full", 32'(bus.full), 1);
    q = {8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6};
    expect_stream(q, 3, FL - 1, 8'hC6, "t4");

    // reset mid-frame during data bit 3
    wait_idle();
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h37;
    tick();
    bus.wr_data = 8'h12;
    tick();
    bus.wr_data = 8'h34;
    tick();
    bus.wr_en = 1'b0;
    repeat (43) tick();
    check("t5 bit3 low", 32'(tx), 0);
    #1 reset = 1'b1;
    #1;
    check("t5 async tx", 32'(tx), 1);
    check("t5 busy", 32'(busy), 0);
    check("t5 count", 32'(bus.count), 0);
    check("t5 empty", 32'(bus.empty), 1);
    check("t5 full", 32'(bus.full), 0);
    tick();
    reset = 1'b0;
    tick();
    lows = 0;
    bsy  = 0;
    repeat (3 * FL) begin
      if (!tx) lows++;
      if (busy) bsy++;
      tick();
    end
    check("t5 residual tx", 32'(lows), 0);
    check("t5 residual busy", 32'(bsy), 0);

    // random bytes against a mid-bit receiver model
    begin
      logic [7:0] exp_q[$];
      fork
        begin
          int w;
          logic [7:0] b;
          for (int i = 0; i < 200; i++) begin
            w = 0;
            while (bus.full && w < 2000) begin
              tick();
              w++;
            end
            check("t6 full wait", 32'(w < 2000), 1);
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            bus.wr_en   = 1'b1;
            bus.wr_data = b;
            tick();
            bus.wr_en = 1'b0;
            repeat ($urandom_range(0, 30)) tick();
          end
        end
        begin
          int w;
          logic [7:0] r;
          for (int i = 0; i < 200; i++) begin
            w = 0;
            while (tx && w < 3000) begin
              tick();
              w++;
            end
            check("t6 start wait", 32'(w < 3000), 1);
            if (w >= 3000) break;
            repeat (DIV / 2) tick();
            check("t6 start bit", 32'(tx), 0);
            for (int j = 0; j < 8; j++) begin
              repeat (DIV) tick();
              r[j] = tx;
            end
            repeat (DIV) tick();
            check("t6 stop bit", 32'(tx), 1);
            check("t6 queue", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
              check("t6 byte", 32'(r), 32'(exp_q.pop_front()));
            end
          end
        end
      join
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
